stream_unpacker: RTL and testbench

STREAM_UNPACKER -- requirements
Module: stream_unpacker

---
 rtl/stream_unpacker_if.sv | 18 +
 rtl/stream_unpacker.sv | 103 ++++++++++
 tb/tb_stream_unpacker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_unpacker_if.sv
// +--------------------------------------------------------------------+
// | stream_intf : valid/ready stream with a parameterised payload      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

interface stream_intf #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] payload;

  modport in  (input  valid, input  payload, output ready);
  modport out (output valid, output payload, input  ready);
endinterface

`default_nettype wire

// File: rtl/stream_unpacker.sv
// +--------------------------------------------------------------------+
// | stream_unpacker : splits WORD_WIDTH*LANES beats into LANES words,  |
// | lane 0 first. Optional out_last via STREAM_UNPACKER_LAST_EN.       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module stream_unpacker #(
  parameter logic [0:0] CLOCK_INFO = 1'b0,
  parameter int         WORD_WIDTH = 8,
  parameter int         LANES      = 4
) (
  input  logic      clk,
  input  logic      rst,
  stream_intf.in    stream_in,
  stream_intf.out   stream_out
`ifdef STREAM_UNPACKER_LAST_EN
  ,
  output logic      out_last
`endif
);

  localparam int C_LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int C_BEAT_W = WORD_WIDTH * LANES;

  // Elaboration-time width checks on the attached interfaces.
  if ($bits(stream_in.payload) != C_BEAT_W) begin : g_chk_in_width
    $error("stream_unpacker: stream_in payload width must be WORD_WIDTH*LANES");
  end
  if ($bits(stream_out.payload) != WORD_WIDTH) begin : g_chk_out_width
    $error("stream_unpacker: stream_out payload width must be WORD_WIDTH");
  end
  // Clock descriptor kept for integration compatibility; registers here are local flops.
  if ($bits(CLOCK_INFO) != 1) begin : g_chk_clock_info
    $error("stream_unpacker: unexpected CLOCK_INFO width");
  end

  logic [C_BEAT_W-1:0]   hold_q,  hold_d;
  logic [C_LW-1:0]       lane_q,  lane_d;
  logic                  valid_q, valid_d;

  logic                  w_last_lane;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_out_fire;
  logic [WORD_WIDTH-1:0] w_payload;

  assign w_last_lane = (lane_q == C_LW'(LANES - 1));
  assign w_in_ready  = !valid_q || (w_last_lane && stream_out.ready);
  assign w_accept    = stream_in.valid && w_in_ready;
  assign w_out_fire  = valid_q && stream_out.ready;

  always_comb begin
    hold_d  = hold_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    if (w_accept) begin
      // Covers the last-lane handoff too, so a new beat follows with no bubble.
      hold_d  = stream_in.payload;
      lane_d  = '0;
      valid_d = 1'b1;
    end else if (w_out_fire) begin
      if (w_last_lane) begin
        lane_d  = '0;
        valid_d = 1'b0;
      end else begin
        lane_d  = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    w_payload = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == C_LW'(l)) begin
        w_payload = hold_q[l*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign stream_in.ready    = w_in_ready;
  assign stream_out.valid   = valid_q;
  assign stream_out.payload = w_payload;

`ifdef STREAM_UNPACKER_LAST_EN
  assign out_last = valid_q && w_last_lane;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_unpacker.sv
// +--------------------------------------------------------------------+
// | tb_stream_unpacker : directed checks for stream_unpacker           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_stream_unpacker;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  stream_intf #(.WIDTH(32)) a_in ();
  stream_intf #(.WIDTH(8))  a_out ();
  stream_intf #(.WIDTH(8))  b_in ();
  stream_intf #(.WIDTH(8))  b_out ();

`ifdef STREAM_UNPACKER_LAST_EN
  logic a_last;
  logic b_last;
`endif

  stream_unpacker #(.WORD_WIDTH(8), .LANES(4)) u_dut_a (
    .clk        (clk),
    .rst        (rst_n),
    .stream_in  (a_in),
    .stream_out (a_out)
`ifdef STREAM_UNPACKER_LAST_EN
    ,
    .out_last   (a_last)
`endif
  );

  stream_unpacker #(.WORD_WIDTH(8), .LANES(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst_n),
    .stream_in  (b_in),
    .stream_out (b_out)
`ifdef STREAM_UNPACKER_LAST_EN
    ,
    .out_last   (b_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect the four lanes of word w on consecutive cycles, out.ready assumed high.
  task automatic expect_words(input string tag, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val({tag, "_vld"}, 32'(a_out.valid), 32'd1);
      check_val({tag, "_data"}, 32'(a_out.payload), 32'(w[8*k +: 8]));
`ifdef STREAM_UNPACKER_LAST_EN
      check_val({tag, "_last"}, 32'(a_last), (k == 3) ? 32'd1 : 32'd0);
`endif
      step();
    end
  endtask

  task automatic accept_beat(input logic [31:0] w);
    a_in.valid   = 1'b1;
    a_in.payload = w;
    @(negedge clk);
    check_val("acc_rdy", 32'(a_in.ready), 32'd1);
    step();
    a_in.valid = 1'b0;
  endtask

  logic [7:0] b_vals [2];
  int         pi;
  int         oi;
  int         cyc;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_in.valid = 1'b0;  a_in.payload = '0;  a_out.ready = 1'b0;
    b_in.valid = 1'b0;  b_in.payload = '0;  b_out.ready = 1'b0;
    b_vals[0] = 8'h5A;
    b_vals[1] = 8'hA5;

    #2;
    check_val("rst_vld", 32'(a_out.valid), 32'd0);
    check_val("rst_rdy", 32'(a_in.ready), 32'd1);
`ifdef STREAM_UNPACKER_LAST_EN
    check_val("rst_last", 32'(a_last), 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;

    // Single beat
    a_out.ready = 1'b1;
    accept_beat(32'h44332211);
    expect_words("single", 32'h44332211);
    @(negedge clk);
    check_val("single_idle", 32'(a_out.valid), 32'd0);
    step();

    // Back-to-back beats, no bubble
    a_in.valid   = 1'b1;
    a_in.payload = 32'h44332211;
    @(negedge clk);
    check_val("b2b_rdy0", 32'(a_in.ready), 32'd1);
    step();
    a_in.payload = 32'h88776655;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("b2b_vld", 32'(a_out.valid), 32'd1);
      check_val("b2b_data", 32'(a_out.payload), 32'h11 * (k + 1));
      check_val("b2b_rdy", 32'(a_in.ready), (k == 3 || k == 7) ? 32'd1 : 32'd0);
      step();
      if (k == 3) a_in.valid = 1'b0;
    end
    @(negedge clk);
    check_val("b2b_idle", 32'(a_out.valid), 32'd0);
    step();

    // Backpressure on 0x22 while a competing beat is offered
    accept_beat(32'h44332211);
    a_in.valid   = 1'b1;
    a_in.payload = 32'hDEADBEEF;
    @(negedge clk);
    check_val("bp_data0", 32'(a_out.payload), 32'h11);
    check_val("bp_rdy0", 32'(a_in.ready), 32'd0);
    step();
    a_out.ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check_val("bp_hold_vld", 32'(a_out.valid), 32'd1);
      check_val("bp_hold_data", 32'(a_out.payload), 32'h22);
      check_val("bp_hold_rdy", 32'(a_in.ready), 32'd0);
      step();
    end
    a_out.ready = 1'b1;
    a_in.valid  = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check_val("bp_data", 32'(a_out.payload), 32'h11 * (k + 1));
      step();
    end
    @(negedge clk);
    check_val("bp_idle", 32'(a_out.valid), 32'd0);
    step();

    // Reset mid-beat after 0x22 transfers
    accept_beat(32'h44332211);
    @(negedge clk);
    check_val("mr_data0", 32'(a_out.payload), 32'h11);
    step();
    @(negedge clk);
    check_val("mr_data1", 32'(a_out.payload), 32'h22);
    step();
    rst_n = 1'b0;
    #1;
    check_val("mr_vld", 32'(a_out.valid), 32'd0);
    check_val("mr_rdy", 32'(a_in.ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    accept_beat(32'hDDCCBBAA);
    expect_words("mr_next", 32'hDDCCBBAA);
    @(negedge clk);
    check_val("mr_idle", 32'(a_out.valid), 32'd0);
    step();

    // LANES=1 with random output backpressure
    pi  = 0;
    oi  = 0;
    cyc = 0;
    while (oi < 2 && cyc < 200) begin
      b_in.valid   = (pi < 2);
      b_in.payload = (pi < 2) ? b_vals[pi] : 8'h00;
      b_out.ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("l1_rdy", 32'(b_in.ready), 32'(!b_out.valid || b_out.ready));
      if (b_out.valid && b_out.ready) begin
        check_val("l1_data", 32'(b_out.payload), 32'(b_vals[oi]));
        oi++;
      end
      if (b_in.valid && b_in.ready) pi++;
      step();
      cyc++;
    end
    b_in.valid  = 1'b0;
    b_out.ready = 1'b1;
    check_val("l1_out_cnt", 32'(oi), 32'd2);
    check_val("l1_in_cnt", 32'(pi), 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("l1_idle", 32'(b_out.valid), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
